// File: rtl/prop_window_monitor.sv
// prop_window_monitor: on-chip checker for "trig |-> ##[MIN_DLY:MAX_DLY] resp"
// on NUM_CH independent channels. Each channel runs one attempt at a time and
// reports a registered pass/fail pulse. Fails are latched per channel, and all
// decisions feed two shared saturating counters. en=0 acts as "disable iff".
module prop_window_monitor #(
  parameter int NUM_CH    = 4,
  parameter int MIN_DLY   = 1,
  parameter int MAX_DLY   = 8,
  parameter int CNT_W     = 8,
  parameter int EDGE_MODE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [NUM_CH-1:0] trig,
  input  logic [NUM_CH-1:0] resp,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] pass_pulse,
  output logic [NUM_CH-1:0] fail_pulse,
  output logic [NUM_CH-1:0] fail_sticky,
  output logic              any_fail,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt
);

  // Delay counter holds 1..MAX_DLY; popcount holds 0..NUM_CH.
  localparam int DW = $clog2(MAX_DLY + 1);
  localparam int PW = $clog2(NUM_CH + 1);
  localparam int SW = CNT_W + PW;

  localparam logic [DW-1:0]    MIN_K   = DW'(MIN_DLY);
  localparam logic [DW-1:0]    MAX_K   = DW'(MAX_DLY);
  localparam logic [DW-1:0]    ONE_K   = DW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  logic [NUM_CH-1:0] trig_q;
  logic [NUM_CH-1:0] trig_evt;
  logic [NUM_CH-1:0] pass_now;
  logic [NUM_CH-1:0] fail_now;

  logic [PW-1:0]    pass_pop;
  logic [PW-1:0]    fail_pop;
  logic [SW-1:0]    pass_sum;
  logic [SW-1:0]    fail_sum;
  logic [CNT_W-1:0] pass_next;
  logic [CNT_W-1:0] fail_next;

  // Illegal parameter combinations are rejected when the design is elaborated.
  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("prop_window_monitor: NUM_CH must be in 1..16");
  end
  if (MIN_DLY < 1) begin : g_bad_min_dly
    $error("prop_window_monitor: MIN_DLY must be >= 1");
  end
  if (MAX_DLY < MIN_DLY) begin : g_bad_max_dly
    $error("prop_window_monitor: MAX_DLY must be >= MIN_DLY");
  end

  // Previous trig sample for edge detection. It is captured on every edge
  // regardless of state or en, so a trig held across a disable does not look
  // like a fresh rising edge afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_q <= '0;
    end else begin
      trig_q <= trig;
    end
  end

  if (EDGE_MODE != 0) begin : g_edge_trig
    assign trig_evt = trig & ~trig_q;
  end else begin : g_level_trig
    assign trig_evt = trig;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_t        state;
    logic [DW-1:0] dly;
    logic          busy_r;
    logic          pass_r;
    logic          fail_r;
    logic          in_window;
    logic          at_limit;

    // dly is the index of the edge currently being sampled, counted from the
    // trigger edge.
    assign in_window = (dly >= MIN_K);
    assign at_limit  = (dly == MAX_K);

    // Decision at this edge. A response inside the window passes. An early
    // response fails. Reaching MAX_DLY with no response is a timeout fail.
    assign pass_now[g] = en && (state == WAIT) && resp[g] && in_window;
    assign fail_now[g] = en && (state == WAIT) &&
                         ((resp[g] && !in_window) || (!resp[g] && at_limit));

    // Attempt FSM. IDLE arms on a trigger event. WAIT counts edges until the
    // deciding edge, then returns to IDLE. The pulses are registered, so they
    // appear in the cycle after the deciding edge.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state  <= IDLE;
        dly    <= '0;
        busy_r <= 1'b0;
        pass_r <= 1'b0;
        fail_r <= 1'b0;
      end else if (!en) begin
        state  <= IDLE;
        dly    <= '0;
        busy_r <= 1'b0;
        pass_r <= 1'b0;
        fail_r <= 1'b0;
      end else begin
        pass_r <= pass_now[g];
        fail_r <= fail_now[g];
        case (state)
          IDLE: begin
            if (trig_evt[g]) begin
              state  <= WAIT;
              dly    <= ONE_K;
              busy_r <= 1'b1;
            end
          end
          WAIT: begin
            if (pass_now[g] || fail_now[g]) begin
              state  <= IDLE;
              dly    <= '0;
              busy_r <= 1'b0;
            end else begin
              dly <= dly + ONE_K;
            end
          end
          default: begin
            state  <= IDLE;
            dly    <= '0;
            busy_r <= 1'b0;
          end
        endcase
      end
    end

    assign busy[g]       = busy_r;
    assign pass_pulse[g] = pass_r;
    assign fail_pulse[g] = fail_r;
  end

  // Count the decisions made across all channels at this edge.
  always_comb begin
    pass_pop = '0;
    fail_pop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pass_pop = pass_pop + PW'(pass_now[i]);
      fail_pop = fail_pop + PW'(fail_now[i]);
    end
  end

  // Saturating add. The sum is formed wider than the counter, so a multi-channel
  // add that overshoots the maximum clamps instead of wrapping.
  always_comb begin
    pass_sum  = SW'(pass_cnt) + SW'(pass_pop);
    fail_sum  = SW'(fail_cnt) + SW'(fail_pop);
    pass_next = (pass_sum > SW'(CNT_MAX)) ? CNT_MAX : pass_sum[CNT_W-1:0];
    fail_next = (fail_sum > SW'(CNT_MAX)) ? CNT_MAX : fail_sum[CNT_W-1:0];
  end

  // Aggregate counters. clr takes priority over a decision at the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else if (clr) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else begin
      pass_cnt <= pass_next;
      fail_cnt <= fail_next;
    end
  end

  // Sticky fail flags. Each flag sets together with its fail pulse, and clr wins
  // over a fail at the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_sticky <= '0;
    end else if (clr) begin
      fail_sticky <= '0;
    end else begin
      fail_sticky <= fail_sticky | fail_now;
    end
  end

  assign any_fail = |fail_sticky;

endmodule

// File: tb/tb_prop_window_monitor.sv
// Bench for prop_window_monitor. It runs three instances side by side:
//   a: CNT_W=8, edge mode;  b: CNT_W=2, edge mode;  c: CNT_W=8, level mode.
// All use MIN_DLY=2, MAX_DLY=5. The reference model tracks, for each channel,
// how many edges have passed since the trigger.
module tb_prop_window_monitor;
  localparam int MIN = 2;
  localparam int MAX = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] trig = '0;
  logic [3:0] resp = '0;

  logic [3:0] busy_o [3];
  logic [3:0] pp_o [3];
  logic [3:0] fp_o [3];
  logic [3:0] st_o [3];
  logic       any_o [3];
  logic [7:0] pc_a, fc_a, pc_c, fc_c;
  logic [1:0] pc_b, fc_b;

  int tests = 0;
  int fails = 0;

  // Model state. age is -1 when the channel is idle, otherwise the number of
  // edges since the trigger edge.
  int       age [3][4];
  bit [3:0] prev [3];
  bit [3:0] m_pp [3];
  bit [3:0] m_fp [3];
  bit [3:0] m_st [3];
  int       m_pc [3];
  int       m_fc [3];

  always #5 clk = ~clk;

  prop_window_monitor #(.NUM_CH(4), .MIN_DLY(MIN), .MAX_DLY(MAX), .CNT_W(8), .EDGE_MODE(1)) u_a (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .trig(trig), .resp(resp),
    .busy(busy_o[0]), .pass_pulse(pp_o[0]), .fail_pulse(fp_o[0]), .fail_sticky(st_o[0]),
    .any_fail(any_o[0]), .pass_cnt(pc_a), .fail_cnt(fc_a));

  prop_window_monitor #(.NUM_CH(4), .MIN_DLY(MIN), .MAX_DLY(MAX), .CNT_W(2), .EDGE_MODE(1)) u_b (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .trig(trig), .resp(resp),
    .busy(busy_o[1]), .pass_pulse(pp_o[1]), .fail_pulse(fp_o[1]), .fail_sticky(st_o[1]),
    .any_fail(any_o[1]), .pass_cnt(pc_b), .fail_cnt(fc_b));

  prop_window_monitor #(.NUM_CH(4), .MIN_DLY(MIN), .MAX_DLY(MAX), .CNT_W(8), .EDGE_MODE(0)) u_c (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .trig(trig), .resp(resp),
    .busy(busy_o[2]), .pass_pulse(pp_o[2]), .fail_pulse(fp_o[2]), .fail_sticky(st_o[2]),
    .any_fail(any_o[2]), .pass_cnt(pc_c), .fail_cnt(fc_c));

  function automatic int cmax(input int k);
    return (k == 1) ? 3 : 255;
  endfunction

  function automatic bit edge_mode(input int k);
    return (k != 2);
  endfunction

  function automatic logic [32:0] act_vec(input int k);
    logic [7:0] pc, fc;
    case (k)
      0:       begin pc = pc_a;         fc = fc_a;         end
      1:       begin pc = {6'b0, pc_b}; fc = {6'b0, fc_b}; end
      default: begin pc = pc_c;         fc = fc_c;         end
    endcase
    return {busy_o[k], pp_o[k], fp_o[k], st_o[k], any_o[k], pc, fc};
  endfunction

  function automatic logic [32:0] exp_vec(input int k);
    logic [3:0] b;
    for (int i = 0; i < 4; i++) b[i] = (age[k][i] >= 0);
    return {b, m_pp[k], m_fp[k], m_st[k], |m_st[k], 8'(m_pc[k]), 8'(m_fc[k])};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) age[k][i] = -1;
      prev[k] = '0; m_pp[k] = '0; m_fp[k] = '0; m_st[k] = '0;
      m_pc[k] = 0; m_fc[k] = 0;
    end
  endtask

  // One clock edge of the property rules, applied to the inputs sampled at that edge.
  task automatic model_edge(input int k);
    bit [3:0] pp, fp;
    int e;
    pp = '0; fp = '0;
    for (int i = 0; i < 4; i++) begin
      if (!en) begin
        age[k][i] = -1;
      end else if (age[k][i] >= 0) begin
        e = age[k][i] + 1;
        if (resp[i]) begin
          if (e >= MIN) pp[i] = 1'b1; else fp[i] = 1'b1;
          age[k][i] = -1;
        end else if (e == MAX) begin
          fp[i] = 1'b1;
          age[k][i] = -1;
        end else begin
          age[k][i] = e;
        end
      end else if (edge_mode(k) ? (trig[i] && !prev[k][i]) : trig[i]) begin
        age[k][i] = 0;
      end
    end
    prev[k] = trig;
    m_pp[k] = pp;
    m_fp[k] = fp;
    if (clr) begin
      m_pc[k] = 0; m_fc[k] = 0; m_st[k] = '0;
    end else begin
      m_pc[k] = (m_pc[k] + $countones(pp) > cmax(k)) ? cmax(k) : m_pc[k] + $countones(pp);
      m_fc[k] = (m_fc[k] + $countones(fp) > cmax(k)) ? cmax(k) : m_fc[k] + $countones(fp);
      m_st[k] = m_st[k] | fp;
    end
  endtask

  // Drive inputs, take one edge, advance the model, then settle 1 time unit past the edge.
  task automatic step(input logic [3:0] t, input logic [3:0] r, input logic e, input logic c);
    trig = t; resp = r; en = e; clr = c;
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_edge(k);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    trig = '0; resp = '0; en = 1'b0; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (act_vec(k) !== 33'd0) begin
        fails++; $display("[TB] FAIL reset_state[%0d]: got %h, expected 0", k, act_vec(k));
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_single_pass();
    step(4'b0001, 4'b0000, 1, 0);
    tests++; if (busy_o[0] !== 4'b0001) begin fails++; $display("[TB] FAIL pass_busy_e0: got %b, expected 0001", busy_o[0]); end
    step(4'b0000, 4'b0000, 1, 0);
    step(4'b0000, 4'b0000, 1, 0);
    tests++; if (busy_o[0] !== 4'b0001) begin fails++; $display("[TB] FAIL pass_busy_e2: got %b, expected 0001", busy_o[0]); end
    step(4'b0000, 4'b0001, 1, 0);
    tests++; if (pp_o[0] !== 4'b0001) begin fails++; $display("[TB] FAIL pass_pulse: got %b, expected 0001", pp_o[0]); end
    tests++; if (busy_o[0] !== 4'b0000) begin fails++; $display("[TB] FAIL pass_busy_done: got %b, expected 0000", busy_o[0]); end
    tests++; if (pc_a !== 8'd1 || fc_a !== 8'd0) begin fails++; $display("[TB] FAIL pass_counts: got %0d/%0d, expected 1/0", pc_a, fc_a); end
    step(4'b0000, 4'b0000, 1, 0);
    tests++; if (pp_o[0] !== 4'b0000) begin fails++; $display("[TB] FAIL pass_pulse_one_cycle: got %b, expected 0000", pp_o[0]); end
    for (int k = 0; k < 3; k++) begin
      tests++; if (act_vec(k) !== exp_vec(k)) begin fails++; $display("[TB] FAIL pass_model[%0d]: got %h, expected %h", k, act_vec(k), exp_vec(k)); end
    end
  endtask

  task automatic test_early_fail();
    step(4'b0001, 4'b0000, 1, 0);
    step(4'b0000, 4'b0001, 1, 0);
    tests++; if (fp_o[0] !== 4'b0001) begin fails++; $display("[TB] FAIL early_fail_pulse: got %b, expected 0001", fp_o[0]); end
    tests++; if (st_o[0] !== 4'b0001 || any_o[0] !== 1'b1) begin fails++; $display("[TB] FAIL early_sticky: got %b/%b, expected 0001/1", st_o[0], any_o[0]); end
    tests++; if (fc_a !== 8'd1) begin fails++; $display("[TB] FAIL early_fail_cnt: got %0d, expected 1", fc_a); end
    step(4'b0000, 4'b0000, 1, 0);
    tests++; if (fp_o[0] !== 4'b0000 || st_o[0] !== 4'b0001) begin fails++; $display("[TB] FAIL early_after: got %b/%b, expected 0000/0001", fp_o[0], st_o[0]); end
    for (int k = 0; k < 3; k++) begin
      tests++; if (act_vec(k) !== exp_vec(k)) begin fails++; $display("[TB] FAIL early_model[%0d]: got %h, expected %h", k, act_vec(k), exp_vec(k)); end
    end
  endtask

  task automatic test_timeout();
    step(4'b0000, 4'b0000, 1, 1);
    tests++; if (fc_a !== 8'd0 || st_o[0] !== 4'b0000) begin fails++; $display("[TB] FAIL clr_idle: got %0d/%b, expected 0/0000", fc_a, st_o[0]); end
    step(4'b0010, 4'b0000, 1, 0);
    repeat (4) step(4'b0000, 4'b0000, 1, 0);
    tests++; if (busy_o[0] !== 4'b0010) begin fails++; $display("[TB] FAIL timeout_busy_e4: got %b, expected 0010", busy_o[0]); end
    step(4'b0000, 4'b0000, 1, 0);
    tests++; if (fp_o[0] !== 4'b0010 || busy_o[0] !== 4'b0000) begin fails++; $display("[TB] FAIL timeout_fail: got %b/%b, expected 0010/0000", fp_o[0], busy_o[0]); end
    tests++; if (fc_a !== 8'd1) begin fails++; $display("[TB] FAIL timeout_cnt: got %0d, expected 1", fc_a); end
    step(4'b0010, 4'b0000, 1, 0);
    tests++; if (busy_o[0] !== 4'b0010) begin fails++; $display("[TB] FAIL timeout_restart: got %b, expected 0010", busy_o[0]); end
    step(4'b0000, 4'b0000, 1, 0);
    step(4'b0000, 4'b0010, 1, 0);
    tests++; if (pp_o[0] !== 4'b0010 || pc_a !== 8'd1) begin fails++; $display("[TB] FAIL restart_pass: got %b/%0d, expected 0010/1", pp_o[0], pc_a); end
    for (int k = 0; k < 3; k++) begin
      tests++; if (act_vec(k) !== exp_vec(k)) begin fails++; $display("[TB] FAIL timeout_model[%0d]: got %h, expected %h", k, act_vec(k), exp_vec(k)); end
    end
  endtask

  task automatic test_all_channels();
    step(4'b0000, 4'b0000, 1, 1);
    step(4'b1111, 4'b0000, 1, 0);
    step(4'b0000, 4'b0000, 1, 0);
    step(4'b0000, 4'b1111, 1, 0);
    tests++; if (pp_o[0] !== 4'b1111) begin fails++; $display("[TB] FAIL all_pass_pulse: got %b, expected 1111", pp_o[0]); end
    tests++; if (pc_a !== 8'd4) begin fails++; $display("[TB] FAIL all_pass_cnt: got %0d, expected 4", pc_a); end
    tests++; if (pc_b !== 2'd3) begin fails++; $display("[TB] FAIL all_pass_sat_clamp: got %0d, expected 3", pc_b); end
    step(4'b0000, 4'b0000, 1, 0);
    tests++; if (pp_o[0] !== 4'b0000) begin fails++; $display("[TB] FAIL all_pulse_one_cycle: got %b, expected 0000", pp_o[0]); end
    step(4'b1111, 4'b0000, 1, 0);
    step(4'b0000, 4'b0000, 1, 0);
    step(4'b0000, 4'b1111, 1, 0);
    tests++; if (pc_a !== 8'd8 || pc_b !== 2'd3) begin fails++; $display("[TB] FAIL all_repeat_sat: got %0d/%0d, expected 8/3", pc_a, pc_b); end
    for (int k = 0; k < 3; k++) begin
      tests++; if (act_vec(k) !== exp_vec(k)) begin fails++; $display("[TB] FAIL all_model[%0d]: got %h, expected %h", k, act_vec(k), exp_vec(k)); end
    end
  endtask

  task automatic test_disable();
    step(4'b0000, 4'b0000, 1, 1);
    step(4'b0100, 4'b0000, 1, 0);
    step(4'b0100, 4'b0000, 1, 0);
    step(4'b0100, 4'b0000, 1, 0);
    tests++; if (busy_o[0] !== 4'b0100) begin fails++; $display("[TB] FAIL dis_busy_before: got %b, expected 0100", busy_o[0]); end
    step(4'b0100, 4'b0000, 0, 0);
    tests++; if (busy_o[0] !== 4'b0000 || pp_o[0] !== 4'b0000 || fp_o[0] !== 4'b0000) begin
      fails++; $display("[TB] FAIL dis_abandon: got %b/%b/%b, expected 0000/0000/0000", busy_o[0], pp_o[0], fp_o[0]);
    end
    tests++; if (pc_a !== 8'd0 || fc_a !== 8'd0) begin fails++; $display("[TB] FAIL dis_counts: got %0d/%0d, expected 0/0", pc_a, fc_a); end
    step(4'b0100, 4'b0000, 1, 0);
    tests++; if (busy_o[0] !== 4'b0000) begin fails++; $display("[TB] FAIL dis_edge_no_retrig: got %b, expected 0000", busy_o[0]); end
    tests++; if (busy_o[2] !== 4'b0100) begin fails++; $display("[TB] FAIL dis_level_retrig: got %b, expected 0100", busy_o[2]); end
    repeat (6) step(4'b0000, 4'b0000, 1, 0);
    tests++; if (fc_c !== 8'd1 || fc_a !== 8'd0) begin fails++; $display("[TB] FAIL dis_level_timeout: got %0d/%0d, expected 1/0", fc_c, fc_a); end
    for (int k = 0; k < 3; k++) begin
      tests++; if (act_vec(k) !== exp_vec(k)) begin fails++; $display("[TB] FAIL dis_model[%0d]: got %h, expected %h", k, act_vec(k), exp_vec(k)); end
    end
  endtask

  task automatic test_reset_mid();
    step(4'b0001, 4'b0000, 1, 0);
    step(4'b0000, 4'b0000, 1, 0);
    tests++; if (busy_o[0] !== 4'b0001) begin fails++; $display("[TB] FAIL rstmid_busy: got %b, expected 0001", busy_o[0]); end
    #2 rst = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      tests++; if (act_vec(k) !== 33'd0) begin fails++; $display("[TB] FAIL rstmid_zero[%0d]: got %h, expected 0", k, act_vec(k)); end
    end
    rst = 1'b0;
  endtask

  task automatic test_clr_fail();
    step(4'b0001, 4'b0000, 1, 0);
    step(4'b0000, 4'b0001, 1, 0);
    tests++; if (fc_a !== 8'd1) begin fails++; $display("[TB] FAIL clrf_pre_cnt: got %0d, expected 1", fc_a); end
    step(4'b0001, 4'b0000, 1, 0);
    tests++; if (busy_o[0] !== 4'b0001) begin fails++; $display("[TB] FAIL clrf_rearm: got %b, expected 0001", busy_o[0]); end
    step(4'b0000, 4'b0001, 1, 1);
    tests++; if (fp_o[0] !== 4'b0001) begin fails++; $display("[TB] FAIL clrf_pulse: got %b, expected 0001", fp_o[0]); end
    tests++; if (fc_a !== 8'd0 || st_o[0] !== 4'b0000 || any_o[0] !== 1'b0) begin
      fails++; $display("[TB] FAIL clrf_clear_wins: got %0d/%b/%b, expected 0/0000/0", fc_a, st_o[0], any_o[0]);
    end
    for (int k = 0; k < 3; k++) begin
      tests++; if (act_vec(k) !== exp_vec(k)) begin fails++; $display("[TB] FAIL clrf_model[%0d]: got %h, expected %h", k, act_vec(k), exp_vec(k)); end
    end
  endtask

  task automatic test_back_to_back();
    step(4'b0001, 4'b0000, 1, 0);
    step(4'b0000, 4'b0000, 1, 0);
    step(4'b0001, 4'b0001, 1, 0);
    tests++; if (pp_o[0] !== 4'b0001 || busy_o[0] !== 4'b0000) begin fails++; $display("[TB] FAIL b2b_decide: got %b/%b, expected 0001/0000", pp_o[0], busy_o[0]); end
    step(4'b0001, 4'b0000, 1, 0);
    tests++; if (busy_o[0] !== 4'b0000) begin fails++; $display("[TB] FAIL b2b_edge_held: got %b, expected 0000", busy_o[0]); end
    tests++; if (busy_o[2] !== 4'b0001) begin fails++; $display("[TB] FAIL b2b_level_rearm: got %b, expected 0001", busy_o[2]); end
    repeat (6) step(4'b0000, 4'b0000, 1, 0);
    for (int k = 0; k < 3; k++) begin
      tests++; if (act_vec(k) !== exp_vec(k)) begin fails++; $display("[TB] FAIL b2b_model[%0d]: got %h, expected %h", k, act_vec(k), exp_vec(k)); end
    end
  endtask

  task automatic test_random();
    logic [3:0] t, r;
    logic e, c;
    for (int n = 0; n < 1500; n++) begin
      t = 4'($urandom);
      for (int i = 0; i < 4; i++) r[i] = ($urandom_range(0, 3) == 0);
      e = ($urandom_range(0, 24) != 0);
      c = ($urandom_range(0, 39) == 0);
      step(t, r, e, c);
      for (int k = 0; k < 3; k++) begin
        tests++; if (act_vec(k) !== exp_vec(k)) begin fails++; $display("[TB] FAIL rand_model[%0d] cycle %0d: got %h, expected %h", k, n, act_vec(k), exp_vec(k)); end
      end
      if ($urandom_range(0, 199) == 0) begin
        #2 rst = 1'b1;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
          tests++; if (act_vec(k) !== 33'd0) begin fails++; $display("[TB] FAIL rand_reset[%0d]: got %h, expected 0", k, act_vec(k)); end
        end
        rst = 1'b0;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_pass();
    test_early_fail();
    test_timeout();
    test_all_channels();
    test_disable();
    test_reset_mid();
    test_clr_fail();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prop_window_monitor.md
Name: prop_window_monitor

Overview:
- Synthesizable, parametrised temporal-property monitor with NUM_CH independent channels.
- Each channel checks the property "trigger |-> ##[MIN_DLY:MAX_DLY] response" in hardware and reports pass/fail pulses, sticky fail flags and aggregate saturating counters.
- Supports rising-edge or level triggering, plus a "disable iff" enable.
- Instantiated beside DUT blocks as an on-chip checker; its status can also be observed by the bench.

Parameters:
NUM_CH, 4, number of independent channels (1..16)
MIN_DLY, 1, earliest legal response edge after trigger (>=1)
MAX_DLY, 8, latest legal response edge after trigger (>=MIN_DLY)
CNT_W, 8, width of pass/fail counters
EDGE_MODE, 1, 1: trigger on rising edge of trig; 0: trigger on trig level while idle

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
en  input  1  check enable; 0 behaves as "disable iff (!en)"
clr  input  1  synchronous clear of counters and sticky flags
trig  input  NUM_CH  per-channel antecedent
resp  input  NUM_CH  per-channel consequent
busy  output  NUM_CH  channel has an attempt in progress
pass_pulse  output  NUM_CH  one-cycle pass indication
fail_pulse  output  NUM_CH  one-cycle fail indication
fail_sticky  output  NUM_CH  latched fail per channel
any_fail  output  1  OR of fail_sticky
pass_cnt  output  CNT_W  total passes, saturating
fail_cnt  output  CNT_W  total fails, saturating

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset: all outputs 0, all channels IDLE, trig_q = 0, delay counters 0. Because trig_q resets to 0, trig already high at the first edge after reset counts as a rising edge.
- trig_q register captures trig every edge, regardless of state or en.
- Trigger event: EDGE_MODE=1: trig & ~trig_q. EDGE_MODE=0: trig.
- Per-channel FSM has two states, IDLE and WAIT. Delay counter width is clog2(MAX_DLY+1).
- IDLE -> WAIT: at edge E0 where en=1 and a trigger event is sampled; counter loads 1. busy is high from E0 until the deciding edge.
- WAIT: at edge Ek, where k is the counter value (1..MAX_DLY):
  - resp=1 and k>=MIN_DLY: pass, go IDLE.
  - resp=1 and k<MIN_DLY: fail (early response), go IDLE.
  - resp=0 and k==MAX_DLY: fail (timeout), go IDLE.
  - Otherwise: counter increments, stay in WAIT.
- Response sampled at E0 is ignored.
- Triggers while in WAIT are ignored: no overlapping attempts.
- A new trigger is accepted at the first edge after the deciding edge. In EDGE_MODE=1, trig held high does not retrigger.
- Outputs are registered at the deciding edge: pass_pulse/fail_pulse are high for exactly one cycle after it.
- fail_sticky sets together with fail_pulse. any_fail is the combinational OR of the fail_sticky registers.
- Counters: at the same edge, pass_cnt += popcount(pass results) and fail_cnt += popcount(fail results), both saturating at 2^CNT_W-1 (no wrap). A multi-channel add that would exceed the maximum clamps to the maximum.
- en=0 sampled at an edge:
  - Every channel goes IDLE, in-flight attempts are abandoned with no pulse.
  - Counters and sticky flags hold.
  - Pulses go 0 next cycle.
- clr=1 sampled at an edge: pass_cnt, fail_cnt and fail_sticky go 0; attempts and pulses are unaffected.
- clr coinciding with a decision: the pulse is still emitted; clr wins for counters and sticky (values end at 0).
- rst asserted mid-attempt: immediate asynchronous return to the reset state, no pulse.
- Parameter legality (MIN_DLY>=1, MAX_DLY>=MIN_DLY, NUM_CH 1..16) is checked at elaboration with $error.

Test Plan:
(Defaults NUM_CH=4, CNT_W=8, EDGE_MODE=1 unless noted; MIN_DLY=2, MAX_DLY=5.)
1. trig[0] rises at E0, resp[0]=1 only at E3 -> busy[0] high E0..E3, pass_pulse[0] high one cycle after E3, pass_cnt=1, fail_cnt=0.
2. trig[0] rises at E0, resp[0]=1 at E1 -> fail_pulse[0] one cycle after E1, fail_sticky[0]=1, any_fail=1, fail_cnt=1.
3. trig[1] rises, resp[1] held 0 -> fail_pulse[1] after E5, busy[1] low after E5, fail_cnt=1; a second trig rise one edge later starts a new attempt.
4. All 4 channels trigger at the same edge, resp=4'hF at E2 -> pass_pulse=4'hF for one cycle, pass_cnt 0->4; with CNT_W=2, a repeat saturates pass_cnt at 3.
5. Attempt on ch2 with en dropped at E3 -> no pulse, busy[2]=0 after E3, counters unchanged. trig held high through re-enable -> no new attempt in EDGE_MODE=1; with EDGE_MODE=0 a new attempt starts.
6. rst pulsed between edges during WAIT -> all outputs 0 immediately. clr at the same edge as a fail decision -> fail_pulse=1 for one cycle, fail_cnt=0, fail_sticky=0.
